// File: rtl/sha3_pkg.sv
// Shared types and constants for the AXI-Stream Keccak absorber.
//   keccak_state_t  : 5x5 lanes of 64 bits, indexed [x][y]
//   sha3_mode_e     : TUSER mode encoding (224/256/384/512)
//   absorb_state_e  : absorber FSM states, also exported as a debug output
//   rate_lanes()    : number of rate lanes for a mode
//   to_state()      : flat 1600-bit vector -> lane array, lane (x,y) at bit 64*(x+5y)
package sha3_pkg;

  typedef logic [0:4][0:4][63:0] keccak_state_t;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } sha3_mode_e;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_PADBLK = 2'd2
  } absorb_state_e;

  localparam int STATE_BITS     = 1600;
  localparam int STATE_BYTES    = 200;
  localparam int RATE_LANES_224 = 18;
  localparam int RATE_LANES_256 = 17;
  localparam int RATE_LANES_384 = 13;
  localparam int RATE_LANES_512 = 9;
  localparam logic [7:0] PAD_FIRST = 8'h06;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  function automatic int rate_lanes(input logic [1:0] mode);
    case (mode)
      2'd0:    return RATE_LANES_224;
      2'd1:    return RATE_LANES_256;
      2'd2:    return RATE_LANES_384;
      default: return RATE_LANES_512;
    endcase
  endfunction

  // The packed lane array flattens in the opposite order to the Keccak lane
  // numbering, so lanes are moved explicitly.
  function automatic keccak_state_t to_state(input logic [STATE_BITS-1:0] flat);
    keccak_state_t s;
    for (int x = 0; x < 5; x++) begin
      for (int y = 0; y < 5; y++) begin
        s[x][y] = flat[64*(x+5*y) +: 64];
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/axis_keccak_absorber_if.sv
// Bundle of the absorber's two handshakes: the AXI-Stream message input and
// the block output toward the permutation core.
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both 1; the sender holds data/valid stable until
// that edge, and ready may be low at any time.
//   slave  : absorber view (consumes the stream, produces blocks)
//   master : source/sink view (produces the stream, consumes blocks)
interface axis_keccak_absorber_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;
  logic [1:0]              s_axis_tuser;
  sha3_pkg::keccak_state_t blk_data;
  logic                    blk_valid;
  logic                    blk_ready;
  logic                    blk_last;
  logic [1:0]              blk_mode;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, blk_ready,
    output s_axis_tready, blk_data, blk_valid, blk_last, blk_mode
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, blk_ready,
    input  s_axis_tready, blk_data, blk_valid, blk_last, blk_mode
  );
endinterface

// File: rtl/sha3_pad_gen.sv
// Combinational SHA-3 pad mask: 0x06 at byte n_bytes, 0x80 at the last rate
// byte of the mode; both land in one byte (0x86) when n_bytes is rate-1.
//   mode    in  2     SHA-3 mode, selects the rate
//   n_bytes in  8     message bytes already in the block
//   mask    out 1600  OR-mask applied to the flat block buffer
module sha3_pad_gen
  import sha3_pkg::*;
(
  input  logic [1:0]            mode,
  input  logic [7:0]            n_bytes,
  output logic [STATE_BITS-1:0] mask
);
  logic [7:0] last_byte;
  assign last_byte = 8'(rate_lanes(mode) * 8 - 1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < STATE_BYTES; i++) begin
      if (i == int'(n_bytes))   mask[8*i +: 8] = mask[8*i +: 8] | PAD_FIRST;
      if (i == int'(last_byte)) mask[8*i +: 8] = mask[8*i +: 8] | PAD_LAST;
    end
  end
endmodule

// File: rtl/axis_keccak_absorber.sv
// AXI-Stream absorber: packs message beats into rate-sized Keccak blocks and
// hands each block to the permutation core as a 1600-bit state.
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   bus (slave)   : s_axis_* message stream in, blk_* block handshake out
//   dbg_state     : current FSM state
// Build option: define SHA3_PAD_EN to insert SHA-3 padding (0x06..0x80),
// including an extra pad-only block when the message ends on a block
// boundary. Without it, TLAST flushes the zero-filled block with last=1 and
// the source supplies pre-padded data.
module axis_keccak_absorber
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axis_keccak_absorber_if.slave bus,
  output absorb_state_e         dbg_state
);
  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64))
  begin : g_bad_width
    $error("axis_keccak_absorber: DATA_WIDTH must be 8, 16, 32 or 64");
  end

  absorb_state_e         state_q;
  logic [7:0]            cnt_q;
  logic [STATE_BITS-1:0] buf_q;
  logic [1:0]            mode_q;
  logic                  msg_start_q;
  logic                  tready_q;
  logic                  valid_q;
  logic                  last_q;

  logic [1:0]            eff_mode;
  logic [7:0]            bpb_m1;
  logic                  accept;
  logic                  block_full;
  logic [STATE_BITS-1:0] beat_buf;

  // TUSER only matters on the first beat of a message; afterwards the
  // latched mode drives the block length.
  assign eff_mode   = (state_q == ST_FILL && msg_start_q) ? bus.s_axis_tuser : mode_q;
  assign bpb_m1     = 8'(rate_lanes(eff_mode) * 64 / DATA_WIDTH - 1);
  assign accept     = (state_q == ST_FILL) && bus.s_axis_tvalid && tready_q;
  assign block_full = (cnt_q == bpb_m1);

  always_comb begin
    beat_buf = buf_q;
    beat_buf[11'(cnt_q) * 11'(DATA_WIDTH) +: DATA_WIDTH] = bus.s_axis_tdata;
  end

`ifdef SHA3_PAD_EN
  logic                  pad_pend_q;
  logic [7:0]            pad_n;
  logic [1:0]            pad_mode;
  logic [STATE_BITS-1:0] pad_mask;

  // In PADBLK the block holds no message bytes, so the pad starts at byte 0.
  assign pad_n    = (state_q == ST_PADBLK) ? 8'd0 : 8'((int'(cnt_q) + 1) * BYTES_PER_BEAT);
  assign pad_mode = (state_q == ST_FILL) ? eff_mode : mode_q;

  sha3_pad_gen u_pad_gen (
    .mode    (pad_mode),
    .n_bytes (pad_n),
    .mask    (pad_mask)
  );
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      buf_q       <= '0;
      mode_q      <= '0;
      msg_start_q <= 1'b1;
      tready_q    <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
`ifdef SHA3_PAD_EN
      pad_pend_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_FILL: begin
          tready_q <= 1'b1;
          if (accept) begin
            cnt_q       <= cnt_q + 8'd1;
            mode_q      <= eff_mode;
            msg_start_q <= bus.s_axis_tlast;
            if (bus.s_axis_tlast || block_full) begin
              state_q  <= ST_EMIT;
              tready_q <= 1'b0;
              valid_q  <= 1'b1;
`ifdef SHA3_PAD_EN
              if (bus.s_axis_tlast && !block_full) begin
                buf_q  <= beat_buf | pad_mask;
                last_q <= 1'b1;
              end else begin
                // A message ending exactly on a block boundary needs a
                // following pad-only block.
                buf_q      <= beat_buf;
                last_q     <= 1'b0;
                pad_pend_q <= bus.s_axis_tlast;
              end
`else
              buf_q  <= beat_buf;
              last_q <= bus.s_axis_tlast;
`endif
            end else begin
              buf_q <= beat_buf;
            end
          end
        end

        ST_EMIT: begin
          if (bus.blk_ready) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
`ifdef SHA3_PAD_EN
            if (pad_pend_q) begin
              state_q <= ST_PADBLK;
            end else begin
              state_q  <= ST_FILL;
              tready_q <= 1'b1;
            end
`else
            state_q  <= ST_FILL;
            tready_q <= 1'b1;
`endif
          end
        end

`ifdef SHA3_PAD_EN
        ST_PADBLK: begin
          buf_q      <= pad_mask;
          pad_pend_q <= 1'b0;
          last_q     <= 1'b1;
          valid_q    <= 1'b1;
          state_q    <= ST_EMIT;
        end
`endif

        default: begin
          state_q  <= ST_FILL;
          tready_q <= 1'b0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_axis_tready = tready_q;
  assign bus.blk_data      = to_state(buf_q);
  assign bus.blk_valid     = valid_q;
  assign bus.blk_last      = last_q;
  assign bus.blk_mode      = mode_q;
  assign dbg_state         = state_q;
endmodule
